alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single processor ALU between two requesters, e.g. the execute stage and an address/branch-compare unit. Requesters hand over opcode and operands with a valid/ready handshake. The block grants round-robin, drives the ALU's opcode, input1, input2 and alu_enable for the required number of cycles, and captures alu_out. It returns the result to the owning requester with a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered processor ALU between two requesters.
// Requests are granted round-robin, the ALU is driven for ALU_LATENCY+1
// cycles, and the captured result is handed back to the owning requester.
module alu_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4:0]           req0_opcode,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4:0]           req1_opcode,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [WORD_SIZE-1:0] resp_result,
  output logic [4:0]           alu_opcode,
  output logic [WORD_SIZE-1:0] alu_input1,
  output logic [WORD_SIZE-1:0] alu_input2,
  output logic                 alu_enable,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 busy,
  output logic [15:0]          op_count
);

  // Cycle counter must be able to reach ALU_LATENCY; never narrower than 1 bit.
  localparam int CNT_RAW = $clog2(ALU_LATENCY + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   owner_reg;
  logic                   last_grant_reg;
  logic [4:0]             alu_opcode_reg;
  logic [WORD_SIZE-1:0]   alu_input1_reg;
  logic [WORD_SIZE-1:0]   alu_input2_reg;
  logic [WORD_SIZE-1:0]   resp_result_reg;
  logic [15:0]            op_count_reg;

  logic grant_valid;
  logic grant;
  logic accept;
  logic exec_done;
  logic resp_taken;

  // Round-robin choice: on contention the requester not served last wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state_reg == ST_IDLE) && grant_valid;
  assign exec_done  = (state_reg == ST_EXEC) && (cnt_reg == CNT_LAST);
  assign resp_taken = owner_reg ? resp1_ready : resp0_ready;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: accept, run the ALU for its latency, then wait for the owner.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (grant_valid) state_next = ST_EXEC;
      ST_EXEC: if (exec_done)   state_next = ST_RESP;
      ST_RESP: if (resp_taken)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and ALU strobe outputs decoded from the current state.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_enable  = 1'b0;
    busy        = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        req0_ready = grant_valid && !grant;
        req1_ready = grant_valid && grant;
      end
      ST_EXEC: alu_enable = 1'b1;
      ST_RESP: begin
        resp0_valid = !owner_reg;
        resp1_valid = owner_reg;
      end
      default: ;
    endcase
  end

  // Operand latch on acceptance, latency count and result capture in EXEC.
  // ALU operand registers only change on acceptance so the ALU sees no
  // spurious activity outside EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg         <= '0;
      owner_reg       <= 1'b0;
      last_grant_reg  <= 1'b1;
      alu_opcode_reg  <= '0;
      alu_input1_reg  <= '0;
      alu_input2_reg  <= '0;
      resp_result_reg <= '0;
      op_count_reg    <= '0;
    end else begin
      if (accept) begin
        alu_opcode_reg <= grant ? req1_opcode : req0_opcode;
        alu_input1_reg <= grant ? req1_a : req0_a;
        alu_input2_reg <= grant ? req1_b : req0_b;
        owner_reg      <= grant;
        last_grant_reg <= grant;
        cnt_reg        <= '0;
      end else if (state_reg == ST_EXEC) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (exec_done) begin
          resp_result_reg <= alu_out;
          op_count_reg    <= op_count_reg + 16'd1;
        end
      end
    end
  end

  assign alu_opcode  = alu_opcode_reg;
  assign alu_input1  = alu_input1_reg;
  assign alu_input2  = alu_input2_reg;
  assign resp_result = resp_result_reg;
  assign op_count    = op_count_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (ALU latency 1 and 3), each with its own ALU
// model, checked every cycle against a transaction-level model plus
// hand-computed expectations for the directed scenarios.
module tb_alu_arbiter;

  localparam logic [4:0] OP_NOT = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_EQ  = 5'd6;
  localparam logic [4:0] OP_LT  = 5'd7;

  logic clock = 1'b0;
  logic reset;

  // Index [d] selects the arbiter (0: latency 1, 1: latency 3), [n] the requester.
  logic        rq_valid [2][2];
  logic        rq_ready [2][2];
  logic [4:0]  rq_op    [2][2];
  logic [15:0] rq_a     [2][2];
  logic [15:0] rq_b     [2][2];
  logic        rs_valid [2][2];
  logic        rs_ready [2][2];
  logic [15:0] rs_result [2];
  logic [4:0]  alu_op    [2];
  logic [15:0] alu_in1   [2];
  logic [15:0] alu_in2   [2];
  logic [15:0] alu_res   [2];
  logic        alu_en    [2];
  logic        busy      [2];
  logic [15:0] op_count  [2];

  int checks = 0;
  int failures = 0;

  // Transaction-level reference state per arbiter.
  bit          m_pend  [2];
  bit          m_done  [2];
  int          m_owner [2];
  int          m_last  [2];
  int          m_age   [2];
  logic [4:0]  m_op    [2];
  logic [15:0] m_a     [2];
  logic [15:0] m_b     [2];
  logic [15:0] m_res   [2];
  logic [15:0] m_cnt   [2];

  always #5 clock = ~clock;

  alu_arbiter #(.WORD_SIZE(16), .ALU_LATENCY(1)) u_dut_lat1 (
    .clock(clock), .reset(reset),
    .req0_valid(rq_valid[0][0]), .req0_ready(rq_ready[0][0]), .req0_opcode(rq_op[0][0]),
    .req0_a(rq_a[0][0]), .req0_b(rq_b[0][0]),
    .resp0_valid(rs_valid[0][0]), .resp0_ready(rs_ready[0][0]),
    .req1_valid(rq_valid[0][1]), .req1_ready(rq_ready[0][1]), .req1_opcode(rq_op[0][1]),
    .req1_a(rq_a[0][1]), .req1_b(rq_b[0][1]),
    .resp1_valid(rs_valid[0][1]), .resp1_ready(rs_ready[0][1]),
    .resp_result(rs_result[0]), .alu_opcode(alu_op[0]), .alu_input1(alu_in1[0]),
    .alu_input2(alu_in2[0]), .alu_enable(alu_en[0]), .alu_out(alu_res[0]),
    .busy(busy[0]), .op_count(op_count[0])
  );

  alu_arbiter #(.WORD_SIZE(16), .ALU_LATENCY(3)) u_dut_lat3 (
    .clock(clock), .reset(reset),
    .req0_valid(rq_valid[1][0]), .req0_ready(rq_ready[1][0]), .req0_opcode(rq_op[1][0]),
    .req0_a(rq_a[1][0]), .req0_b(rq_b[1][0]),
    .resp0_valid(rs_valid[1][0]), .resp0_ready(rs_ready[1][0]),
    .req1_valid(rq_valid[1][1]), .req1_ready(rq_ready[1][1]), .req1_opcode(rq_op[1][1]),
    .req1_a(rq_a[1][1]), .req1_b(rq_b[1][1]),
    .resp1_valid(rs_valid[1][1]), .resp1_ready(rs_ready[1][1]),
    .resp_result(rs_result[1]), .alu_opcode(alu_op[1]), .alu_input1(alu_in1[1]),
    .alu_input2(alu_in2[1]), .alu_enable(alu_en[1]), .alu_out(alu_res[1]),
    .busy(busy[1]), .op_count(op_count[1])
  );

  function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] x,
                                         input logic [15:0] y);
    case (op)
      OP_NOT:  return ~x;
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_EQ:   return (x == y) ? 16'h0001 : 16'h0000;
      OP_LT:   return (x < y) ? 16'h0001 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // Registered ALU models: one stage for arbiter 0, three stages for arbiter 1.
  logic [15:0] pipe_l1;
  logic [15:0] pipe_l3 [3];
  always @(posedge clock) begin
    if (alu_en[0]) pipe_l1 <= alu_fn(alu_op[0], alu_in1[0], alu_in2[0]);
    if (alu_en[1]) begin
      pipe_l3[0] <= alu_fn(alu_op[1], alu_in1[1], alu_in2[1]);
      pipe_l3[1] <= pipe_l3[0];
      pipe_l3[2] <= pipe_l3[1];
    end
  end
  assign alu_res[0] = pipe_l1;
  assign alu_res[1] = pipe_l3[2];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Compare one arbiter against the model, then advance the model by one edge.
  task automatic model_step(input int d);
    int lat;
    int g;
    bit idle;
    lat = (d == 0) ? 1 : 3;
    if (reset) begin
      m_pend[d] = 0; m_done[d] = 0; m_owner[d] = 0; m_last[d] = 1; m_age[d] = 0;
      m_op[d] = '0; m_a[d] = '0; m_b[d] = '0; m_res[d] = '0; m_cnt[d] = '0;
    end
    idle = !m_pend[d];
    g = -1;
    if (idle && rq_valid[d][0] && rq_valid[d][1]) g = 1 - m_last[d];
    else if (idle && rq_valid[d][0]) g = 0;
    else if (idle && rq_valid[d][1]) g = 1;

    chk("busy", d, 32'(busy[d]), 32'(m_pend[d]));
    chk("alu_enable", d, 32'(alu_en[d]), 32'(m_pend[d] && !m_done[d]));
    chk("resp0_valid", d, 32'(rs_valid[d][0]), 32'(m_done[d] && m_owner[d] == 0));
    chk("resp1_valid", d, 32'(rs_valid[d][1]), 32'(m_done[d] && m_owner[d] == 1));
    chk("req0_ready", d, 32'(rq_ready[d][0]), 32'(g == 0));
    chk("req1_ready", d, 32'(rq_ready[d][1]), 32'(g == 1));
    chk("resp_result", d, 32'(rs_result[d]), 32'(m_res[d]));
    chk("alu_opcode", d, 32'(alu_op[d]), 32'(m_op[d]));
    chk("alu_input1", d, 32'(alu_in1[d]), 32'(m_a[d]));
    chk("alu_input2", d, 32'(alu_in2[d]), 32'(m_b[d]));
    chk("op_count", d, 32'(op_count[d]), 32'(m_cnt[d]));

    if (!reset) begin
      if (m_pend[d] && !m_done[d]) begin
        m_age[d]++;
        if (m_age[d] == lat + 1) begin
          m_done[d] = 1;
          m_res[d]  = alu_fn(m_op[d], m_a[d], m_b[d]);
          m_cnt[d]  = m_cnt[d] + 16'd1;
        end
      end else if (m_done[d] && rs_ready[d][m_owner[d]]) begin
        m_pend[d] = 0;
        m_done[d] = 0;
      end
      if (g >= 0) begin
        m_pend[d] = 1; m_owner[d] = g; m_last[d] = g; m_age[d] = 0;
        m_op[d] = rq_op[d][g]; m_a[d] = rq_a[d][g]; m_b[d] = rq_b[d][g];
      end
    end
  endtask

  task automatic set_req(input int d, input int n, input logic [4:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    rq_op[d][n] = op; rq_a[d][n] = a; rq_b[d][n] = b; rq_valid[d][n] = 1'b1;
  endtask

  // Wait (bounded) for ready, let the handshake edge pass, drop valid.
  task automatic accept(input int d, input int n);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rq_ready[d][n]) break;
    end
    chk("accept_ready", d, 32'(rq_ready[d][n]), 32'd1);
    @(posedge clock); #1;
    rq_valid[d][n] = 1'b0;
  endtask

  // Wait (bounded) for the response valid of requester n.
  task automatic wait_resp(input int d, input int n);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rs_valid[d][n]) break;
    end
    chk("resp_seen", d, 32'(rs_valid[d][n]), 32'd1);
  endtask

  // One complete operation with zero-wait response acceptance.
  task automatic run_one(input int d, input int n, input logic [4:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         output int en_cyc, output int lat, output logic [15:0] res);
    en_cyc = 0; lat = -1; res = '0;
    rs_ready[d][n] = 1'b1;
    set_req(d, n, op, a, b);
    accept(d, n);
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (alu_en[d]) en_cyc++;
      if (rs_valid[d][n]) begin
        lat = i - 1;
        res = rs_result[d];
        break;
      end
    end
    @(posedge clock); #1;
    rs_ready[d][n] = 1'b0;
    $display("op dut%0d req%0d opcode=%0d a=%h b=%h -> result=%h edges=%0d en_cycles=%0d",
             d, n, op, a, b, res, lat, en_cyc);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int en_cyc, lat;
  logic [15:0] res, res0, res1;
  int order[$];
  int exp_order[4] = '{0, 1, 0, 1};
  int g, seen;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        rq_valid[d][n] = 0; rq_op[d][n] = '0; rq_a[d][n] = '0; rq_b[d][n] = '0;
        rs_ready[d][n] = 0;
      end
    end

    fork
      forever begin
        @(negedge clock);
        for (int d = 0; d < 2; d++) model_step(d);
      end
    join_none

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_op_count", d, 32'(op_count[d]), 32'h0);
      chk("rst_resp_result", d, 32'(rs_result[d]), 32'h0);
      chk("rst_alu_enable", d, 32'(alu_en[d]), 32'h0);
      chk("rst_alu_input1", d, 32'(alu_in1[d]), 32'h0);
      chk("rst_busy", d, 32'(busy[d]), 32'h0);
    end
    reset = 1'b0;

    // Single ADD on requester 0
    run_one(0, 0, OP_ADD, 16'h1234, 16'h5678, en_cyc, lat, res);
    chk("add_result", 0, 32'(res), 32'h68AC);
    chk("add_en_cycles", 0, 32'(en_cyc), 32'd2);
    chk("add_latency", 0, 32'(lat), 32'd2);
    chk("add_op_count", 0, 32'(op_count[0]), 32'd1);

    // Contention: both valid together, twice; round-robin order 0,1,0,1
    do_reset();
    rs_ready[0][0] = 1'b1;
    rs_ready[0][1] = 1'b1;
    res0 = '0; res1 = '0;
    for (int round = 0; round < 2; round++) begin
      set_req(0, 0, OP_SUB, 16'h5678, 16'h1234);
      set_req(0, 1, OP_XOR, 16'hAAAA, 16'h5555);
      seen = 0;
      for (int c = 0; c < 40 && seen < 2; c++) begin
        @(negedge clock);
        g = -1;
        if (rq_ready[0][0]) g = 0;
        else if (rq_ready[0][1]) g = 1;
        if (rs_valid[0][0]) begin res0 = rs_result[0]; seen++; end
        if (rs_valid[0][1]) begin res1 = rs_result[0]; seen++; end
        @(posedge clock); #1;
        if (g >= 0) begin
          rq_valid[0][g] = 1'b0;
          order.push_back(g);
          $display("grant dut0 req%0d round=%0d", g, round);
        end
      end
    end
    chk("grant_count", 0, 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("grant_order", 0, (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF,
          32'(exp_order[i]));
    chk("sub_result", 0, 32'(res0), 32'h4444);
    chk("xor_result", 0, 32'(res1), 32'hFFFF);
    chk("rr_op_count", 0, 32'(op_count[0]), 32'd4);
    rs_ready[0][0] = 1'b0;
    rs_ready[0][1] = 1'b0;

    // Held response on requester 1 while requester 0 waits
    set_req(0, 1, OP_ADD, 16'hFFFF, 16'h0001);
    accept(0, 1);
    rs_ready[0][0] = 1'b1;
    set_req(0, 0, OP_AND, 16'h0F0F, 16'h00FF);
    wait_resp(0, 1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_req0_ready", 0, 32'(rq_ready[0][0]), 32'd0);
      chk("hold_alu_enable", 0, 32'(alu_en[0]), 32'd0);
      chk("hold_resp1_valid", 0, 32'(rs_valid[0][1]), 32'd1);
      chk("hold_result", 0, 32'(rs_result[0]), 32'h0000);
      @(negedge clock);
    end
    @(posedge clock); #1;
    rs_ready[0][1] = 1'b1;
    @(posedge clock); #1;
    rs_ready[0][1] = 1'b0;
    $display("resp dut0 req1 released after hold");
    @(negedge clock);
    chk("pending_req0_ready", 0, 32'(rq_ready[0][0]), 32'd1);
    @(posedge clock); #1;
    rq_valid[0][0] = 1'b0;
    wait_resp(0, 0);
    chk("and_result", 0, 32'(rs_result[0]), 32'h000F);
    @(posedge clock); #1;
    rs_ready[0][0] = 1'b0;
    chk("hold_op_count", 0, 32'(op_count[0]), 32'd6);

    // Asynchronous reset one cycle into EXEC discards the operation
    rs_ready[0][0] = 1'b1;
    set_req(0, 0, OP_LT, 16'h1234, 16'h5678);
    accept(0, 0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("arst_alu_enable", 0, 32'(alu_en[0]), 32'd0);
    chk("arst_busy", 0, 32'(busy[0]), 32'd0);
    chk("arst_op_count", 0, 32'(op_count[0]), 32'd0);
    chk("arst_alu_input1", 0, 32'(alu_in1[0]), 32'd0);
    chk("arst_alu_opcode", 0, 32'(alu_op[0]), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    $display("reset dut0 mid-exec");
    repeat (4) @(posedge clock);
    #1;
    chk("arst_no_resp", 0, 32'(rs_valid[0][0]), 32'd0);
    run_one(0, 0, OP_LT, 16'h1234, 16'h5678, en_cyc, lat, res);
    chk("lt_true", 0, 32'(res), 32'h0001);
    run_one(0, 0, OP_LT, 16'h5678, 16'h1234, en_cyc, lat, res);
    chk("lt_false", 0, 32'(res), 32'h0000);
    chk("lt_op_count", 0, 32'(op_count[0]), 32'd2);

    // ALU latency 3
    run_one(1, 0, OP_EQ, 16'h1234, 16'h1234, en_cyc, lat, res);
    chk("eq_true", 1, 32'(res), 32'h0001);
    chk("eq_en_cycles", 1, 32'(en_cyc), 32'd4);
    chk("eq_latency", 1, 32'(lat), 32'd4);
    run_one(1, 0, OP_EQ, 16'h1234, 16'h5678, en_cyc, lat, res);
    chk("eq_false", 1, 32'(res), 32'h0000);

    // op_count wrap from preloaded 0xFFFE
    force u_dut_lat1.op_count_reg = 16'hFFFE;
    m_cnt[0] = 16'hFFFE;
    #1;
    release u_dut_lat1.op_count_reg;
    run_one(0, 1, OP_ADD, 16'h0001, 16'h0001, en_cyc, lat, res);
    chk("cnt_ffff", 0, 32'(op_count[0]), 32'hFFFF);
    run_one(0, 0, OP_OR, 16'h00F0, 16'h0F00, en_cyc, lat, res);
    chk("cnt_wrap", 0, 32'(op_count[0]), 32'h0000);
    chk("or_result", 0, 32'(res), 32'h0FF0);

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
